// File: rtl/rob_multi_cdb_if.sv
// Bundle of dispatch, CDB, operand-read, commit and flush signals around the reorder buffer.
// master drives requests and results; slave is the ROB itself.
interface rob_multi_cdb_if #(
    parameter int ENTRIES = 32,
    parameter int TAG_W   = $clog2(ENTRIES),
    parameter int NCDB    = 2,
    parameter int XLEN    = 32
);
    logic                   dp_valid;
    logic [4:0]             dp_rd;
    logic                   dp_accept;
    logic [TAG_W-1:0]       dp_tag;
    logic                   full;
    logic                   empty;

    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*TAG_W-1:0]  cdb_tag;
    logic [NCDB*XLEN-1:0]   cdb_data;

    logic [TAG_W-1:0]       rd_tag1;
    logic [TAG_W-1:0]       rd_tag2;
    logic [XLEN:0]          rd_data1;
    logic [XLEN:0]          rd_data2;

    logic                   commit_we;
    logic [4:0]             commit_dest;
    logic [XLEN-1:0]        commit_data;
    logic [TAG_W-1:0]       commit_tag;

    logic                   flush;

    modport master (
        output dp_valid, dp_rd, cdb_valid, cdb_tag, cdb_data, rd_tag1, rd_tag2, flush,
        input  dp_accept, dp_tag, full, empty, rd_data1, rd_data2,
               commit_we, commit_dest, commit_data, commit_tag
    );

    modport slave (
        input  dp_valid, dp_rd, cdb_valid, cdb_tag, cdb_data, rd_tag1, rd_tag2, flush,
        output dp_accept, dp_tag, full, empty, rd_data1, rd_data2,
               commit_we, commit_dest, commit_data, commit_tag
    );
endinterface

// File: rtl/rob_multi_cdb.sv
// Reorder buffer with NCDB parallel result buses: in-order allocate and retire,
// out-of-order completion, bypassed operand reads and a full flush.
module rob_multi_cdb #(
    parameter int ENTRIES = 32,
    parameter int TAG_W   = $clog2(ENTRIES),
    parameter int NCDB    = 2,
    parameter int XLEN    = 32
) (
    input  logic              clk,
    input  logic              reset,
    rob_multi_cdb_if.slave    bus
);
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0]       head;
    logic [TAG_W-1:0]       tail;
    logic [CNT_W-1:0]       count;
    logic [ENTRIES-1:0]     valid;
    logic [ENTRIES-1:0]     done;
    logic [4:0]             rd_q   [ENTRIES];
    logic [XLEN-1:0]        data_q [ENTRIES];

    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*TAG_W-1:0]  cdb_tag;
    logic [NCDB*XLEN-1:0]   cdb_data;

    logic                   kill;
    logic                   is_full;
    logic                   is_empty;
    logic                   accept;
    logic                   retire;

    logic [ENTRIES-1:0]     wr_hit;
    logic [XLEN-1:0]        wr_data [ENTRIES];

    assign cdb_valid = bus.cdb_valid;
    assign cdb_tag   = bus.cdb_tag;
    assign cdb_data  = bus.cdb_data;

    // Reset mid-operation clears state exactly like a flush.
    assign kill     = bus.flush | ~reset;
    assign is_full  = (count == CNT_W'(ENTRIES));
    assign is_empty = (count == '0);
    assign accept   = bus.dp_valid & ~is_full & ~kill;
    assign retire   = ~is_empty & done[head] & ~kill;

    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.dp_accept   = accept;
    assign bus.dp_tag      = tail;
    assign bus.commit_we   = retire & (rd_q[head] != 5'd0);
    assign bus.commit_dest = rd_q[head];
    assign bus.commit_data = data_q[head];
    assign bus.commit_tag  = head;

    // Channels are scanned high to low so the lowest index wins a duplicate tag.
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            wr_hit[e]  = 1'b0;
            wr_data[e] = '0;
            for (int i = NCDB - 1; i >= 0; i--) begin
                if (cdb_valid[i] && valid[e] && (cdb_tag[i*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    wr_hit[e]  = 1'b1;
                    wr_data[e] = cdb_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        if (valid[tag] && done[tag]) begin
            res = {1'b1, data_q[tag]};
        end else begin
            for (int i = NCDB - 1; i >= 0; i--) begin
                if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == tag)) begin
                    res = {1'b1, cdb_data[i*XLEN +: XLEN]};
                end
            end
        end
        return res;
    endfunction

    assign bus.rd_data1 = lookup(bus.rd_tag1);
    assign bus.rd_data2 = lookup(bus.rd_tag2);

    // Retire is applied after CDB writes so the head entry always ends up cleared.
    always_ff @(posedge clk) begin
        if (kill) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (wr_hit[e]) begin
                    done[e] <= 1'b1;
                end
            end
            if (accept) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                tail        <= tail + 1'b1;
            end
            if (retire) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CNT_W'(accept) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (!kill) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (wr_hit[e]) begin
                    data_q[e] <= wr_data[e];
                end
            end
            if (accept) begin
                rd_q[tail] <= bus.dp_rd;
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed bench for rob_multi_cdb: reset, commit path, out-of-order completion,
// full/wrap, CDB bypass, silent rd=0 retire and flush/reset recovery.
module tb_rob_multi_cdb;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rob_multi_cdb_if #(.ENTRIES(32), .NCDB(2), .XLEN(32)) bus ();

    rob_multi_cdb #(.ENTRIES(32), .NCDB(2), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dp_valid  = 1'b0;
        bus.dp_rd     = 5'd0;
        bus.cdb_valid = 2'b00;
        bus.cdb_tag   = '0;
        bus.cdb_data  = '0;
        bus.rd_tag1   = 5'd0;
        bus.rd_tag2   = 5'd0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        bus.dp_valid = 1'b1;
        #1;
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %0b want 0", bus.full); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %0b want 1", bus.empty); end
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %0b want 0", bus.commit_we); end
        n_checks++; if (bus.dp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_tag: got %0d want 0", bus.dp_tag); end
        n_checks++; if (bus.dp_accept !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_accept: got %0b want 1", bus.dp_accept); end
        bus.dp_valid = 1'b0;
        #1;
        n_checks++; if (bus.dp_accept !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_noaccept: got %0b want 0", bus.dp_accept); end
    endtask

    task automatic test_basic_commit();
        do_reset();
        bus.dp_valid = 1'b1;
        bus.dp_rd    = 5'd5;
        #1;
        n_checks++; if (bus.dp_accept !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_accept: got %0b want 1", bus.dp_accept); end
        n_checks++; if (bus.dp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL basic_tag: got %0d want 0", bus.dp_tag); end
        tick();
        bus.dp_valid  = 1'b0;
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {5'd0, 5'd0};
        bus.cdb_data  = {32'h0, 32'h0000_1234};
        #1;
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_no_bypass: got %0b want 0", bus.commit_we); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_notempty: got %0b want 0", bus.empty); end
        tick();
        bus.cdb_valid = 2'b00;
        #1;
        n_checks++; if (bus.commit_we !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_we: got %0b want 1", bus.commit_we); end
        n_checks++; if (bus.commit_dest !== 5'd5) begin n_fail++; $display("[TB] FAIL basic_dest: got %0d want 5", bus.commit_dest); end
        n_checks++; if (bus.commit_data !== 32'h0000_1234) begin n_fail++; $display("[TB] FAIL basic_data: got %h want 00001234", bus.commit_data); end
        n_checks++; if (bus.commit_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL basic_ctag: got %0d want 0", bus.commit_tag); end
        tick();
        #1;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_empty_after: got %0b want 1", bus.empty); end
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_we_after: got %0b want 0", bus.commit_we); end
    endtask

    task automatic test_out_of_order();
        logic [4:0]  exp_dest [3];
        logic [31:0] exp_data [3];
        exp_dest = '{5'd1, 5'd2, 5'd3};
        exp_data = '{32'h10, 32'h11, 32'h22};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.dp_valid = 1'b1;
            bus.dp_rd    = 5'(i + 1);
            tick();
        end
        bus.dp_valid  = 1'b0;
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {5'd2, 5'd0};
        bus.cdb_data  = {32'h22, 32'h0};
        tick();
        bus.cdb_tag   = {5'd1, 5'd0};
        bus.cdb_data  = {32'h11, 32'h0};
        #1;
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ooo_hold1: got %0b want 0", bus.commit_we); end
        tick();
        bus.cdb_tag   = {5'd0, 5'd0};
        bus.cdb_data  = {32'h10, 32'h0};
        #1;
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ooo_hold2: got %0b want 0", bus.commit_we); end
        tick();
        bus.cdb_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus.commit_we !== 1'b1) begin n_fail++; $display("[TB] FAIL ooo_we%0d: got %0b want 1", k, bus.commit_we); end
            n_checks++; if (bus.commit_tag !== 5'(k)) begin n_fail++; $display("[TB] FAIL ooo_tag%0d: got %0d want %0d", k, bus.commit_tag, k); end
            n_checks++; if (bus.commit_dest !== exp_dest[k]) begin n_fail++; $display("[TB] FAIL ooo_dest%0d: got %0d want %0d", k, bus.commit_dest, exp_dest[k]); end
            n_checks++; if (bus.commit_data !== exp_data[k]) begin n_fail++; $display("[TB] FAIL ooo_data%0d: got %h want %h", k, bus.commit_data, exp_data[k]); end
            tick();
        end
        #1;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL ooo_empty: got %0b want 1", bus.empty); end
    endtask

    task automatic test_full_wrap();
        int          h;
        int          t;
        logic [4:0]  exp_tag;
        logic [4:0]  exp_dest;
        logic [4:0]  exp_dptag;
        logic [31:0] exp_data;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            bus.dp_valid = 1'b1;
            bus.dp_rd    = 5'((i % 31) + 1);
            #1;
            n_checks++; if (bus.dp_tag !== 5'(i) || bus.dp_accept !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_%0d: got tag %0d acc %0b want tag %0d acc 1", i, bus.dp_tag, bus.dp_accept, i); end
            tick();
        end
        bus.dp_valid  = 1'b0;
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {5'd0, 5'd0};
        bus.cdb_data  = {32'h0, 32'h0000_B000};
        #1;
        n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("[TB] FAIL full_set: got %0b want 1", bus.full); end
        tick();
        bus.cdb_valid = 2'b00;
        bus.dp_valid  = 1'b1;
        bus.dp_rd     = 5'd1;
        #1;
        n_checks++; if (bus.dp_accept !== 1'b0) begin n_fail++; $display("[TB] FAIL full_noaccept: got %0b want 0", bus.dp_accept); end
        n_checks++; if (bus.commit_we !== 1'b1 || bus.commit_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL full_retire: got we %0b tag %0d want we 1 tag 0", bus.commit_we, bus.commit_tag); end
        n_checks++; if (bus.commit_data !== 32'h0000_B000) begin n_fail++; $display("[TB] FAIL full_rdata: got %h want 0000b000", bus.commit_data); end
        tick();
        bus.dp_valid  = 1'b0;
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {5'd0, 5'd1};
        bus.cdb_data  = {32'h0, 32'h0000_CFFF};
        #1;
        n_checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL count31: got full %0b empty %0b want 0 0", bus.full, bus.empty); end
        n_checks++; if (bus.dp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL tail_wrap: got %0d want 0", bus.dp_tag); end
        tick();
        for (int j = 0; j < 40; j++) begin
            h = (1 + j) % 32;
            t = j % 32;
            exp_tag   = 5'(h);
            exp_dest  = 5'((h % 31) + 1);
            exp_dptag = 5'(t);
            exp_data  = 32'(32'hD000 + j - 1);
            bus.dp_valid  = 1'b1;
            bus.dp_rd     = 5'((t % 31) + 1);
            bus.cdb_valid = 2'b01;
            bus.cdb_tag   = {5'd0, 5'((h + 1) % 32)};
            bus.cdb_data  = {32'h0, 32'(32'hD000 + j)};
            #1;
            n_checks++; if (bus.commit_we !== 1'b1 || bus.commit_tag !== exp_tag) begin n_fail++; $display("[TB] FAIL wrap_ret%0d: got we %0b tag %0d want we 1 tag %0d", j, bus.commit_we, bus.commit_tag, exp_tag); end
            n_checks++; if (bus.commit_dest !== exp_dest || bus.commit_data !== exp_data) begin n_fail++; $display("[TB] FAIL wrap_val%0d: got %0d/%h want %0d/%h", j, bus.commit_dest, bus.commit_data, exp_dest, exp_data); end
            n_checks++; if (bus.dp_accept !== 1'b1 || bus.dp_tag !== exp_dptag) begin n_fail++; $display("[TB] FAIL wrap_dp%0d: got acc %0b tag %0d want acc 1 tag %0d", j, bus.dp_accept, bus.dp_tag, exp_dptag); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.dp_valid = 1'b1;
            bus.dp_rd    = 5'(i + 1);
            tick();
        end
        bus.dp_valid  = 1'b0;
        bus.rd_tag1   = 5'd4;
        bus.rd_tag2   = 5'd3;
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {5'd4, 5'd4};
        bus.cdb_data  = {32'hBB, 32'hAA};
        #1;
        n_checks++; if (bus.rd_data1 !== {1'b1, 32'hAA}) begin n_fail++; $display("[TB] FAIL bypass_prio: got %h want 1000000aa", bus.rd_data1); end
        n_checks++; if (bus.rd_data2 !== 33'h0) begin n_fail++; $display("[TB] FAIL bypass_notready: got %h want 0", bus.rd_data2); end
        tick();
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {5'd3, 5'd0};
        bus.cdb_data  = {32'hCC, 32'h0};
        #1;
        n_checks++; if (bus.rd_data1 !== {1'b1, 32'hAA}) begin n_fail++; $display("[TB] FAIL bypass_stored: got %h want 1000000aa", bus.rd_data1); end
        n_checks++; if (bus.rd_data2 !== {1'b1, 32'hCC}) begin n_fail++; $display("[TB] FAIL bypass_ch1: got %h want 1000000cc", bus.rd_data2); end
        tick();
        clear_inputs();
    endtask

    task automatic test_rd_zero();
        do_reset();
        bus.dp_valid = 1'b1;
        bus.dp_rd    = 5'd0;
        tick();
        bus.dp_valid  = 1'b0;
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {5'd0, 5'd0};
        bus.cdb_data  = {32'h0, 32'h55};
        tick();
        bus.cdb_valid = 2'b00;
        #1;
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rd0_we: got %0b want 0", bus.commit_we); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL rd0_pending: got %0b want 0", bus.empty); end
        tick();
        bus.dp_valid = 1'b1;
        bus.dp_rd    = 5'd7;
        #1;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rd0_retired: got %0b want 1", bus.empty); end
        n_checks++; if (bus.dp_tag !== 5'd1) begin n_fail++; $display("[TB] FAIL rd0_nexttag: got %0d want 1", bus.dp_tag); end
        tick();
        clear_inputs();
    endtask

    task automatic test_flush(input bit use_reset);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.dp_valid = 1'b1;
            bus.dp_rd    = 5'(i + 1);
            tick();
        end
        bus.dp_valid  = 1'b0;
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {5'd4, 5'd3};
        bus.cdb_data  = {32'h44, 32'h33};
        tick();
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {5'd0, 5'd0};
        bus.cdb_data  = {32'h0, 32'h100};
        tick();
        if (use_reset) reset = 1'b0;
        else bus.flush = 1'b1;
        bus.dp_valid  = 1'b1;
        bus.dp_rd     = 5'd9;
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {5'd2, 5'd1};
        bus.cdb_data  = {32'h222, 32'h111};
        #1;
        if (!use_reset) begin
            n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_we: got %0b want 0", bus.commit_we); end
            n_checks++; if (bus.dp_accept !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_accept: got %0b want 0", bus.dp_accept); end
        end
        tick();
        clear_inputs();
        reset        = 1'b1;
        bus.rd_tag1  = 5'd1;
        bus.rd_tag2  = 5'd0;
        #1;
        n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("[TB] FAIL flush%0b_empty: got empty %0b full %0b want 1 0", use_reset, bus.empty, bus.full); end
        n_checks++; if (bus.dp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL flush%0b_tag: got %0d want 0", use_reset, bus.dp_tag); end
        n_checks++; if (bus.commit_we !== 1'b0) begin n_fail++; $display("[TB] FAIL flush%0b_we: got %0b want 0", use_reset, bus.commit_we); end
        n_checks++; if (bus.rd_data1 !== 33'h0 || bus.rd_data2 !== 33'h0) begin n_fail++; $display("[TB] FAIL flush%0b_stale: got %h %h want 0 0", use_reset, bus.rd_data1, bus.rd_data2); end
        bus.dp_valid = 1'b1;
        bus.dp_rd    = 5'd9;
        tick();
        bus.dp_valid = 1'b0;
        #1;
        n_checks++; if (bus.commit_we !== 1'b0 || bus.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL flush%0b_fresh: got we %0b empty %0b want 0 0", use_reset, bus.commit_we, bus.empty); end
        n_checks++; if (bus.rd_data2 !== 33'h0) begin n_fail++; $display("[TB] FAIL flush%0b_fresh_rd: got %h want 0", use_reset, bus.rd_data2); end
        tick();
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_commit();
        test_out_of_order();
        test_full_wrap();
        test_bypass();
        test_rd_zero();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_multi_cdb.md
Name: rob_multi_cdb

Overview:
- Parametrised reorder buffer; successor to the single-CDB ROB in cpu_top.
- Sits between dispatch (decode), the execution units' common data buses, and the ARF.
- Allocates in-order entries at dispatch and accepts out-of-order results from NCDB parallel CDB channels.
- Serves two source-operand reads with same-cycle CDB bypass, retires in order one entry per cycle, and supports a full flush.

Parameters:
- ENTRIES, 32, ROB depth; power of two, 4..64.
- TAG_W, $clog2(ENTRIES), width of ROB tag (entry index).
- NCDB, 2, number of CDB channels, 1..4.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; state clears on posedge clk while reset==0.
- dp_valid  in  1  dispatch request.
- dp_rd  in  5  architectural destination register.
- dp_accept  out  1  dp_valid & !full; entry allocated this cycle.
- dp_tag  out  TAG_W  tag of the entry allocated (current tail).
- full  out  1  count==ENTRIES.
- empty  out  1  count==0.
- cdb_valid  in  NCDB  per-channel result valid.
- cdb_tag  in  NCDB*TAG_W  per-channel ROB tag; channel i at [i*TAG_W +: TAG_W].
- cdb_data  in  NCDB*XLEN  per-channel result.
- rd_tag1, rd_tag2  in  TAG_W  operand lookup tags.
- rd_data1, rd_data2  out  XLEN+1  {ready, value}; {0, 0} when not ready.
- commit_we  out  1  ARF write enable.
- commit_dest  out  5  ARF destination.
- commit_data  out  XLEN  ARF data.
- commit_tag  out  TAG_W  tag being retired; ARF clears its rename tag only if it matches.
- flush  in  1  discard all entries.

Behaviour:
- State:
  - head, tail: TAG_W bits each.
  - count: TAG_W+1 bits.
  - Per entry: valid, done, rd[4:0], data[XLEN-1:0].
- Reset (reset==0 at posedge):
  - head=tail=count=0; all valid and done bits = 0.
  - Outputs after reset: full=0, empty=1, commit_we=0, dp_accept=dp_valid, dp_tag=0.
- Dispatch:
  - When dp_accept: entry[tail] <= {valid=1, done=0, rd=dp_rd}.
  - tail <= tail+1 mod ENTRIES.
  - full is evaluated on the pre-update count; a same-cycle retire does not free space for a same-cycle dispatch.
- CDB write:
  - For each channel i with cdb_valid[i] and entry[cdb_tag[i]].valid: done <= 1, data <= cdb_data[i].
  - A tag hitting an invalid entry is ignored.
  - Two channels with the same tag in one cycle: the lowest channel index wins (a protocol error upstream; no other effect).
- Read ports (combinational), evaluated in priority order:
  1. entry.valid & done -> {1, data}.
  2. else a CDB channel this cycle has matching valid tag -> {1, cdb_data}, lowest channel first.
  3. else {0, 0}.
- Retire (combinational outputs, state update at posedge):
  - retire = !empty & entry[head].done & !flush.
  - commit_we = retire & (entry[head].rd != 0).
  - commit_dest, commit_data, commit_tag come from the head entry.
  - On retire: entry[head].valid <= 0, done <= 0, head <= head+1 mod ENTRIES.
  - rd==0 entries retire silently (no ARF write).
  - A CDB result for the head entry arriving in cycle N is retired in cycle N+1; there is no CDB-to-commit bypass.
- count update: count <= count + dp_accept - retire.
- Wrap-around: head and tail wrap from ENTRIES-1 to 0; full/empty come from count only, never from a head==tail compare.
- Flush (has priority over everything):
  - Next state: head=tail=count=0, all valid and done cleared.
  - Dispatch, CDB writes and retire are suppressed that cycle; commit_we=0 while flush=1.
  - dp_accept stays 0 while flush=1.
- Reset mid-operation behaves identically to flush, plus the reset output values.
- No storage is held outside the entry array; the block has no latency beyond the one register stage of entry state.

Test Plan:
- Reset then dispatch rd=5 (tag 0); CDB0 tag0 data=0x1234 in cycle 2 -> cycle 3: commit_we=1, commit_dest=5, commit_data=0x1234, commit_tag=0; empty=1 in cycle 4.
- Out-of-order completion: dispatch rd=1,2,3 (tags 0,1,2); complete tag2, then tag1, then tag0 on CDB1 -> retire order 0,1,2 on consecutive cycles after tag0 completes.
- Fill 32 entries -> full=1; dp_valid=1 with a same-cycle retire -> dp_accept=0, count=31 next cycle. Continue 40 more dispatch/retire pairs -> tags wrap 31->0, data intact.
- Bypass: rd_tag1=4 with entry 4 not done, CDB0 and CDB1 both carry tag 4 (0xAA, 0xBB) -> rd_data1={1,0xAA}; next cycle entry data=0xAA.
- Dispatch rd=0 and complete it -> entry retires (head advances) with commit_we=0.
- 10 entries in flight, 3 done; assert flush one cycle with dp_valid=1 and cdb_valid=2'b11 -> commit_we=0, dp_accept=0; next cycle empty=1, dp_tag=0, the stale CDB results are ignored. Repeat with reset=0 in place of flush -> same end state.
